// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: operand forwarding, load-use and
// branch handling, memory-wait stalling with timeout, and stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic [4:0]       rd_E,
    input  logic             rd_en_E,
    input  logic             br_taken_E,
    input  logic [4:0]       rd_M,
    input  logic             rf_en_M,
    input  logic             mem_req_M,
    input  logic             mem_ack,
    input  logic [4:0]       rd_W,
    input  logic             rf_en_W,
    output logic [1:0]       fwd_a_E,
    output logic [1:0]       fwd_b_E,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               mem_stall;
    logic               load_use;

    assign mem_stall = (state_q != ERR) && mem_req_M && !mem_ack;
    assign load_use  = rd_en_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));

    // Hazard outputs are purely combinational so a memory ack releases the pipe in the same cycle.
    always_comb begin
        fwd_a_E = 2'b00;
        fwd_b_E = 2'b00;
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_W = 1'b0;
        if (!rst) begin
            if (rf_en_M && (rd_M != 5'd0) && (rd_M == rs1_E))
                fwd_a_E = 2'b01;
            else if (rf_en_W && (rd_W != 5'd0) && (rd_W == rs1_E))
                fwd_a_E = 2'b10;
            if (rf_en_M && (rd_M != 5'd0) && (rd_M == rs2_E))
                fwd_b_E = 2'b01;
            else if (rf_en_W && (rd_W != 5'd0) && (rd_W == rs2_E))
                fwd_b_E = 2'b10;

            if ((state_q == ERR) || mem_stall) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else if (br_taken_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // Counters saturate at all-ones so long error runs never wrap back to small values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_F && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if ((flush_D || flush_E) && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 6;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic          rd_en_E, br_taken_E, rf_en_M, mem_req_M, mem_ack, rf_en_W;
    logic [1:0]    fwd_a_E, fwd_b_E;
    logic          stall_F, stall_D, stall_E, stall_M;
    logic          flush_D, flush_E, flush_W, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model state: length of the current memory-stall run, sticky error, counts.
    int mRun;
    bit mErr;
    int mStallCnt;
    int mFlushCnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .rd_en_E(rd_en_E), .br_taken_E(br_taken_E), .rd_M(rd_M), .rf_en_M(rf_en_M),
        .mem_req_M(mem_req_M), .mem_ack(mem_ack), .rd_W(rd_W), .rf_en_W(rf_en_W),
        .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s at %0t: observed %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [1:0] fwdSel(input logic [4:0] rs);
        if (rf_en_M && rd_M != 0 && rd_M == rs) return 2'b01;
        if (rf_en_W && rd_W != 0 && rd_W == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clearInputs();
        rst = 0; rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        rd_en_E = 0; br_taken_E = 0; rf_en_M = 0; mem_req_M = 0; mem_ack = 0; rf_en_W = 0;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic applyStimulus();
        logic [1:0] eA, eB;
        logic [3:0] eStall;
        logic [2:0] eFlush;
        bit memStall, loadUse;
        @(negedge clk);
        eA = 2'b00; eB = 2'b00; eStall = 4'b0000; eFlush = 3'b000;
        memStall = !mErr && mem_req_M && !mem_ack;
        loadUse  = rd_en_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
        if (!rst) begin
            eA = fwdSel(rs1_E);
            eB = fwdSel(rs2_E);
            if (mErr || memStall) begin
                eStall = 4'b1111; eFlush = 3'b001;
            end else if (br_taken_E) begin
                eFlush = 3'b110;
            end else if (loadUse) begin
                eStall = 4'b1100; eFlush = 3'b010;
            end
        end
        checkOutput("fwd_a",     32'(fwd_a_E), 32'(eA));
        checkOutput("fwd_b",     32'(fwd_b_E), 32'(eB));
        checkOutput("stalls",    32'({stall_F, stall_D, stall_E, stall_M}), 32'(eStall));
        checkOutput("flushes",   32'({flush_D, flush_E, flush_W}), 32'(eFlush));
        checkOutput("mem_err",   32'(mem_err), 32'(mErr));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(mStallCnt));
        checkOutput("flush_cnt", 32'(flush_cnt), 32'(mFlushCnt));
        if (rst) begin
            mRun = 0; mErr = 0; mStallCnt = 0; mFlushCnt = 0;
        end else begin
            if (eStall[3] && mStallCnt < CMAX) mStallCnt++;
            if ((eFlush[2] || eFlush[1]) && mFlushCnt < CMAX) mFlushCnt++;
            mRun = memStall ? mRun + 1 : 0;
            if (mRun >= TIMEOUT) mErr = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clearInputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        mRun = 0; mErr = 0; mStallCnt = 0; mFlushCnt = 0;
        applyStimulus();
        rst = 0;

        // Forwarding priority, then writeback-only forwarding.
        rd_M = 5; rf_en_M = 1; rd_W = 5; rf_en_W = 1; rs1_E = 5; rs2_E = 0;
        applyStimulus();
        rf_en_M = 0;
        applyStimulus();
        clearInputs();

        // Load-use alone, then load-use coinciding with a taken branch.
        rd_en_E = 1; rd_E = 7; rs2_D = 7;
        applyStimulus();
        clearInputs();
        applyStimulus();
        rd_en_E = 1; rd_E = 7; rs2_D = 7; br_taken_E = 1;
        applyStimulus();
        clearInputs();

        // Memory wait of three cycles, released by ack.
        mem_req_M = 1;
        repeat (3) applyStimulus();
        mem_ack = 1;
        applyStimulus();
        clearInputs();
        applyStimulus();

        // Timeout into error, ack afterwards does not release, reset clears.
        mem_req_M = 1;
        repeat (6) applyStimulus();
        mem_ack = 1;
        repeat (2) applyStimulus();
        rst = 1;
        applyStimulus();
        clearInputs();
        applyStimulus();

        // Reset in the middle of a memory wait, then a normal load-use.
        mem_req_M = 1;
        repeat (2) applyStimulus();
        rst = 1;
        applyStimulus();
        clearInputs();
        applyStimulus();
        rd_en_E = 1; rd_E = 3; rs1_D = 3;
        applyStimulus();
        clearInputs();

        // Enough branches to drive flush_cnt past saturation.
        br_taken_E = 1;
        repeat (CMAX + 3) applyStimulus();
        clearInputs();
        applyStimulus();

        // Random traffic; an outstanding request is held until acked.
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(0, 99) < 2);
            rs1_D      = 5'($urandom_range(0, 3));
            rs2_D      = 5'($urandom_range(0, 3));
            rs1_E      = 5'($urandom_range(0, 3));
            rs2_E      = 5'($urandom_range(0, 3));
            rd_E       = 5'($urandom_range(0, 3));
            rd_M       = 5'($urandom_range(0, 3));
            rd_W       = 5'($urandom_range(0, 3));
            rd_en_E    = ($urandom_range(0, 99) < 30);
            br_taken_E = ($urandom_range(0, 99) < 15);
            rf_en_M    = ($urandom_range(0, 99) < 50);
            rf_en_W    = ($urandom_range(0, 99) < 50);
            mem_req_M  = (mRun > 0 && !mErr) ? 1'b1 : ($urandom_range(0, 99) < 25);
            mem_ack    = ($urandom_range(0, 99) < 55);
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
